// File: rtl/comb_sweep_pkg.sv
// comb_sweep_pkg: shared state encoding and default sizing for the combinational sweep controller.
package comb_sweep_pkg;
    localparam int N_IN_DEF   = 3;
    localparam int SETTLE_DEF = 1;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;
endpackage

// File: rtl/comb_sweep_cmp.sv
// comb_sweep_cmp: flags any disagreement among three implementation outputs.
module comb_sweep_cmp (
    input  logic y_a,
    input  logic y_b,
    input  logic y_c,
    output logic mismatch
);
    assign mismatch = (y_a ^ y_b) | (y_b ^ y_c);
endmodule

// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: walks all N_IN-bit vectors, holds each SETTLE cycles, counts 3-way disagreements.
// Define STOP_ON_FAIL_EN to end the sweep at the first mismatching vector.
module comb_sweep_ctrl
    import comb_sweep_pkg::*;
#(
    parameter int N_IN   = N_IN_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            y_a,
    input  logic            y_b,
    input  logic            y_c,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   mismatch_count,
    output logic [N_IN-1:0] first_fail_vec
);
    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    state_t     state, state_nx;
    logic [3:0] cnt;
    logic       fail, mis, last, stop;

    comb_sweep_cmp u_cmp (.y_a(y_a), .y_b(y_b), .y_c(y_c), .mismatch(mis));

    assign last = &vec;
`ifdef STOP_ON_FAIL_EN
    assign stop = last | mis;
`else
    assign stop = last;
`endif
    assign busy = state != S_IDLE;
    assign done = state == S_DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = (state == S_IDLE)   ? (start ? S_APPLY : S_IDLE) :
                   (state == S_APPLY)  ? ((cnt == 4'd0) ? S_SAMPLE : S_APPLY) :
                   (state == S_SAMPLE) ? (stop ? S_DONE : S_APPLY) :
                                         S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec            <= '0;
            mismatch_count <= '0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
            fail           <= 1'b0;
            cnt            <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    vec            <= '0;
                    mismatch_count <= '0;
                    first_fail_vec <= '0;
                    pass           <= 1'b0;
                    fail           <= 1'b0;
                    cnt            <= RELOAD;
                end
                S_APPLY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                S_SAMPLE: begin
                    if (mis) begin
                        mismatch_count <= mismatch_count + (N_IN+1)'(1);
                        if (!fail) first_fail_vec <= vec;
                        fail <= 1'b1;
                    end
                    // the last vector (or a stopping failure) keeps vec where it is
                    if (!stop) begin
                        vec <= vec + N_IN'(1);
                        cnt <= RELOAD;
                    end
                end
                S_DONE: pass <= ~fail;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// tb_comb_sweep_ctrl: randomized sweeps of two controllers (SETTLE=1 and SETTLE=3) against a truth-table model.
module tb_comb_sweep_ctrl;
    localparam int NV = 8;

    logic       clk = 1'b0;
    logic       rst1, rst2, start1, start2;
    logic [7:0] tt, fb, fc;
    logic [2:0] vec1, vec2, ffv1, ffv2;
    logic [3:0] mc1, mc2;
    logic       busy1, busy2, done1, done2, pass1, pass2;
    logic       ya1, yb1, yc1, ya2, yb2, yc2;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    assign ya1 = tt[vec1];
    assign yb1 = tt[vec1] ^ fb[vec1];
    assign yc1 = tt[vec1] ^ fc[vec1];
    assign ya2 = tt[vec2];
    assign yb2 = tt[vec2] ^ fb[vec2];
    assign yc2 = tt[vec2] ^ fc[vec2];

    comb_sweep_ctrl #(.N_IN(3), .SETTLE(1)) dut (
        .clk(clk), .rst(rst1), .start(start1), .y_a(ya1), .y_b(yb1), .y_c(yc1),
        .vec(vec1), .busy(busy1), .done(done1), .pass(pass1),
        .mismatch_count(mc1), .first_fail_vec(ffv1)
    );

    comb_sweep_ctrl #(.N_IN(3), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst2), .start(start2), .y_a(ya2), .y_b(yb2), .y_c(yc2),
        .vec(vec2), .busy(busy2), .done(done2), .pass(pass2),
        .mismatch_count(mc2), .first_fail_vec(ffv2)
    );

    function automatic void model(input logic [7:0] b, input logic [7:0] c, input int s,
                                  output int cnt, output int first, output int lastv, output int e);
        cnt   = 0;
        first = -1;
        for (int v = 0; v < NV; v++)
            if (b[v] || c[v]) begin
                cnt++;
                if (first < 0) first = v;
            end
        lastv = NV - 1;
        e     = NV * (s + 1);
`ifdef STOP_ON_FAIL_EN
        if (first >= 0) begin
            cnt   = 1;
            lastv = first;
            e     = (first + 1) * (s + 1);
        end
`endif
    endfunction

    task automatic run_sweep(input int which, input bit hold, input string name);
        int s, cnt, first, lastv, e, xv, xb, xd;
        logic [2:0] ov, of;
        logic [3:0] oc;
        logic ob, od, op;
        s = which ? 3 : 1;
        model(fb, fc, s, cnt, first, lastv, e);
        @(negedge clk);
        if (which) start2 = 1'b1; else start1 = 1'b1;
        for (int k = 0; k <= e + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0 && !hold) begin start1 = 1'b0; start2 = 1'b0; end
            ov = which ? vec2 : vec1;
            ob = which ? busy2 : busy1;
            od = which ? done2 : done1;
            xv = k < e ? k / (s + 1) : lastv;
            xb = (k <= e) ? 1 : 0;
            xd = (k == e) ? 1 : 0;
            checks += 3;
            if (ov !== 3'(xv)) begin errors++; $display("FAIL %s vec k=%0d: got %0d expected %0d", name, k, ov, xv); end
            if (ob !== xb[0]) begin errors++; $display("FAIL %s busy k=%0d: got %0b expected %0d", name, k, ob, xb); end
            if (od !== xd[0]) begin errors++; $display("FAIL %s done k=%0d: got %0b expected %0d", name, k, od, xd); end
        end
        for (int r = 0; r < 2; r++) begin
            op = which ? pass2 : pass1;
            oc = which ? mc2 : mc1;
            of = which ? ffv2 : ffv1;
            checks += 3;
            if (op !== (first < 0)) begin errors++; $display("FAIL %s pass r=%0d: got %0b expected %0b", name, r, op, first < 0); end
            if (oc !== 4'(cnt)) begin errors++; $display("FAIL %s count r=%0d: got %0d expected %0d", name, r, oc, cnt); end
            if (of !== 3'(first < 0 ? 0 : first)) begin errors++; $display("FAIL %s first_fail r=%0d: got %0d expected %0d", name, r, of, first < 0 ? 0 : first); end
            if (hold) break;
            repeat (3) @(posedge clk);
            #1;
        end
        if (hold) begin
            @(posedge clk); #1;
            checks += 2;
            if (busy2 !== 1'b1) begin errors++; $display("FAIL %s restart busy: got %0b expected 1", name, busy2); end
            if (vec2 !== 3'd0) begin errors++; $display("FAIL %s restart vec: got %0d expected 0", name, vec2); end
            start2 = 1'b0;
            rst2   = 1'b1;
            #1;
            checks++;
            if (busy2 !== 1'b0) begin errors++; $display("FAIL %s abort busy: got %0b expected 0", name, busy2); end
            @(negedge clk);
            rst2 = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst1 = 1'b1; rst2 = 1'b1; start1 = 1'b0; start2 = 1'b0;
        tt = 8'h00; fb = 8'h00; fc = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        checks += 7;
        if (vec1 !== 3'd0)  begin errors++; $display("FAIL reset vec: got %0d expected 0", vec1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL reset busy: got %0b expected 0", busy1); end
        if (done1 !== 1'b0) begin errors++; $display("FAIL reset done: got %0b expected 0", done1); end
        if (pass1 !== 1'b0) begin errors++; $display("FAIL reset pass: got %0b expected 0", pass1); end
        if (mc1 !== 4'd0)   begin errors++; $display("FAIL reset count: got %0d expected 0", mc1); end
        if (ffv1 !== 3'd0)  begin errors++; $display("FAIL reset first_fail: got %0d expected 0", ffv1); end
        if (busy2 !== 1'b0) begin errors++; $display("FAIL reset busy3: got %0b expected 0", busy2); end
        @(negedge clk);
        rst1 = 1'b0; rst2 = 1'b0;
    endtask

    task automatic test_all_pass();
        tt = 8'($urandom); fb = 8'h00; fc = 8'h00;
        run_sweep(0, 1'b0, "all_pass");
    endtask

    task automatic test_single_fault();
        tt = 8'($urandom); fb = 8'b0010_0000; fc = 8'h00;
        run_sweep(0, 1'b0, "b_vec5");
    endtask

    task automatic test_all_inverted();
        tt = 8'($urandom); fb = 8'hFF; fc = 8'h00;
        run_sweep(0, 1'b0, "b_inverted");
    endtask

    task automatic test_stop_two_faults();
        tt = 8'($urandom); fb = 8'h00; fc = 8'b0100_0100;
        run_sweep(0, 1'b0, "c_vec2_vec6");
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            tt = 8'($urandom);
            fb = 8'($urandom & $urandom & $urandom);
            fc = 8'($urandom & $urandom & $urandom);
            run_sweep(0, 1'b0, "random");
        end
    endtask

    task automatic test_back_to_back();
        tt = 8'($urandom); fb = 8'h00; fc = 8'h00;
        run_sweep(1, 1'b1, "start_held_settle3");
    endtask

    task automatic test_reset_mid();
        tt = 8'($urandom); fb = 8'h00; fc = 8'h00;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (vec1 !== 3'd4) begin errors++; $display("FAIL mid_reset pre vec: got %0d expected 4", vec1); end
        rst1 = 1'b1;
        #1;
        checks += 5;
        if (vec1 !== 3'd0)  begin errors++; $display("FAIL mid_reset vec: got %0d expected 0", vec1); end
        if (busy1 !== 1'b0) begin errors++; $display("FAIL mid_reset busy: got %0b expected 0", busy1); end
        if (pass1 !== 1'b0) begin errors++; $display("FAIL mid_reset pass: got %0b expected 0", pass1); end
        if (mc1 !== 4'd0)   begin errors++; $display("FAIL mid_reset count: got %0d expected 0", mc1); end
        if (ffv1 !== 3'd0)  begin errors++; $display("FAIL mid_reset first_fail: got %0d expected 0", ffv1); end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done1 !== 1'b0) begin errors++; $display("FAIL mid_reset done k=%0d: got %0b expected 0", k, done1); end
        end
        @(negedge clk);
        rst1 = 1'b0;
        run_sweep(0, 1'b0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_all_pass();
        test_single_fault();
        test_all_inverted();
        test_stop_two_faults();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
